// File: rtl/aer_spike_arbiter_pkg.sv
// Shared types and defaults for the AER spike arbiter slice.
package snn_aer_pkg;

  localparam int DEFAULT_N_NEURONS = 8;
  localparam int DEFAULT_ADDR_W    = 3;
  localparam int DEFAULT_CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Position of the set bit in a one-hot word (0 when nothing is set).
  // The input is a fixed 64-bit word, so arrays of up to 64 neurons are covered.
  function automatic int unsigned onehot_to_index(input logic [63:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/aer_spike_arbiter_picker.sv
// Combinational round-robin picker: first pending neuron at or after rr_ptr, with wrap.
module rr_priority_picker
  import snn_aer_pkg::*;
#(
  parameter int N_NEURONS = DEFAULT_N_NEURONS,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic [N_NEURONS-1:0] pending,
  input  logic [ADDR_W-1:0]    rr_ptr,
  output logic [N_NEURONS-1:0] grant,
  output logic [ADDR_W-1:0]    index
);

  logic found;
  int   pos;

  // Walk the requesters starting at rr_ptr and keep only the first set bit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 0; off < N_NEURONS; off++) begin
      pos = (int'(rr_ptr) + off) % N_NEURONS;
      if (!found && pending[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign index = ADDR_W'(onehot_to_index(64'(grant)));

endmodule

// File: rtl/aer_spike_arbiter.sv
// Serialises single-cycle neuron spikes onto one AER valid/ready port with
// round-robin fairness, timestep flush and lost-spike detection.
module aer_spike_arbiter
  import snn_aer_pkg::*;
#(
  parameter int N_NEURONS = DEFAULT_N_NEURONS,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic                 tick,
  output logic [N_NEURONS-1:0] acks_out,
  output logic                 aer_valid,
  output logic [ADDR_W-1:0]    aer_addr,
  input  logic                 aer_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 drop,
  output logic [CNT_W-1:0]     event_cnt
);

  state_t               state;
  state_t               state_next;
  logic [N_NEURONS-1:0] pending;
  logic [ADDR_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]     run_cnt;
  logic [CNT_W-1:0]     run_cnt_next;
  logic [N_NEURONS-1:0] grant_raw;
  logic [N_NEURONS-1:0] grant;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 load;
  logic                 handshake;
  logic                 drop_set;
  logic                 flush_exit;

  rr_priority_picker #(
    .N_NEURONS(N_NEURONS),
    .ADDR_W   (ADDR_W)
  ) u_picker (
    .pending(pending),
    .rr_ptr (rr_ptr),
    .grant  (grant_raw),
    .index  (grant_idx)
  );

  // The output stage takes a new event whenever it is empty or being emptied.
  assign load      = (!aer_valid || aer_ready) && (pending != '0);
  assign grant     = load ? grant_raw : '0;
  assign handshake = aer_valid && aer_ready;
  // A spike landing on a neuron that is still waiting (and not leaving now) is lost.
  assign drop_set  = |(spikes_in & pending & ~grant);
  assign flush_exit = (state == FLUSH) && (pending == '0) && !aer_valid && (spikes_in == '0);
  assign run_cnt_next = (handshake && (run_cnt != '1)) ? run_cnt + CNT_W'(1) : run_cnt;
  assign busy = (pending != '0) || aer_valid || (state == FLUSH);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: tick starts a flush from IDLE/ACTIVE; flush ends once fully drained.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick)                 state_next = FLUSH;
        else if (pending != '0)   state_next = ACTIVE;
      end
      ACTIVE: begin
        if (tick)                                 state_next = FLUSH;
        else if ((pending == '0) && !aer_valid)   state_next = IDLE;
      end
      FLUSH: begin
        if (flush_exit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending spikes and the round-robin pointer, which advances past each granted neuron.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending & ~grant) | spikes_in;
      if (load) begin
        rr_ptr <= (grant_idx == ADDR_W'(N_NEURONS - 1)) ? '0 : grant_idx + ADDR_W'(1);
      end
    end
  end

  // Output stage: load a new event, or drop valid once the current one is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aer_valid <= 1'b0;
      aer_addr  <= '0;
      acks_out  <= '0;
    end else begin
      acks_out <= grant;
      if (load) begin
        aer_valid <= 1'b1;
        aer_addr  <= grant_idx;
      end else if (handshake) begin
        aer_valid <= 1'b0;
      end
    end
  end

  // Per-timestep event counting, done pulse and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      event_cnt <= '0;
      done      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      done <= flush_exit;
      if (flush_exit) begin
        event_cnt <= run_cnt_next;
        run_cnt   <= '0;
      end else begin
        run_cnt <= run_cnt_next;
      end
      if (done)          drop <= 1'b0;
      else if (drop_set) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Self-checking bench for aer_spike_arbiter: vector table plus hand-written sequences.
module tb_aer_spike_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] spikes_in;
  logic       tick;
  logic [7:0] acks_out;
  logic       aer_valid;
  logic [2:0] aer_addr;
  logic       aer_ready;
  logic       busy;
  logic       done;
  logic       drop;
  logic [7:0] event_cnt;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [7:0] spikes;
    logic       tick;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_addr;
    logic [7:0] exp_acks;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_drop;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  aer_spike_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spikes_in(spikes_in),
    .tick     (tick),
    .acks_out (acks_out),
    .aer_valid(aer_valid),
    .aer_addr (aer_addr),
    .aer_ready(aer_ready),
    .busy     (busy),
    .done     (done),
    .drop     (drop),
    .event_cnt(event_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive inputs for one edge, then settle just past it so outputs reflect that edge.
  task automatic applyStimulus(input logic r, input logic [7:0] s, input logic t, input logic rdy);
    rst_n     = r;
    spikes_in = s;
    tick      = t;
    aer_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic addVec(input string n, input logic r, input logic [7:0] s, input logic t,
                        input logic rdy, input logic v, input logic [2:0] a, input logic [7:0] ak,
                        input logic b, input logic d, input logic dr, input logic [7:0] c);
    vec_t x;
    x.name = n; x.rst_n = r; x.spikes = s; x.tick = t; x.ready = rdy;
    x.exp_valid = v; x.exp_addr = a; x.exp_acks = ak; x.exp_busy = b;
    x.exp_done = d; x.exp_drop = dr; x.exp_cnt = c;
    vecs.push_back(x);
  endtask

  initial begin
    int n3;
    int nev;
    int quiet;
    logic got_done;

    rst_n = 1'b0; spikes_in = '0; tick = 1'b0; aer_ready = 1'b0;

    // Reset, then neurons 0 and 7 together: 0 first, then 7.
    addVec("reset",   0, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    addVec("spk81",   1, 8'h81, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, 8'd0);
    addVec("ev81_a",  1, 8'h00, 0, 1, 1, 3'd0, 8'h01, 1, 0, 0, 8'd0);
    addVec("ev81_b",  1, 8'h00, 0, 1, 1, 3'd7, 8'h80, 1, 0, 0, 8'd0);
    addVec("end81",   1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    addVec("idle81",  1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    // Two full bursts: the pointer wraps back to 0 after neuron 7.
    for (int b = 0; b < 2; b++) begin
      addVec("spkFF", 1, 8'hFF, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, 8'd0);
      for (int i = 0; i < 8; i++)
        addVec("burstFF", 1, 8'h00, 0, 1, 1, 3'(i), 8'(1 << i), 1, 0, 0, 8'd0);
      addVec("endFF", 1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    end
    // Back-pressure with neurons 2 and 5 pending.
    addVec("bp_rst",  0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    addVec("bp_spk",  1, 8'h24, 0, 0, 0, 3'd0, 8'h00, 1, 0, 0, 8'd0);
    addVec("bp_load", 1, 8'h00, 0, 0, 1, 3'd2, 8'h04, 1, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++)
      addVec("bp_hold", 1, 8'h00, 0, 0, 1, 3'd2, 8'h00, 1, 0, 0, 8'd0);
    addVec("bp_rel5", 1, 8'h00, 0, 1, 1, 3'd5, 8'h20, 1, 0, 0, 8'd0);
    addVec("bp_end",  1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    // Flush: four events then done with count 4; then an empty flush from IDLE.
    addVec("fl_rst",  0, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);
    addVec("fl_spk",  1, 8'h0F, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, 8'd0);
    addVec("fl_tick", 1, 8'h00, 1, 1, 1, 3'd0, 8'h01, 1, 0, 0, 8'd0);
    addVec("fl_ev1",  1, 8'h00, 0, 1, 1, 3'd1, 8'h02, 1, 0, 0, 8'd0);
    addVec("fl_ev2",  1, 8'h00, 0, 1, 1, 3'd2, 8'h04, 1, 0, 0, 8'd0);
    addVec("fl_ev3",  1, 8'h00, 0, 1, 1, 3'd3, 8'h08, 1, 0, 0, 8'd0);
    addVec("fl_drain",1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 1, 0, 0, 8'd0);
    addVec("fl_done", 1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 1, 0, 8'd4);
    addVec("fl_after",1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd4);
    addVec("it_tick", 1, 8'h00, 1, 1, 0, 3'd0, 8'h00, 1, 0, 0, 8'd4);
    addVec("it_done", 1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 1, 0, 8'd0);
    addVec("it_after",1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].spikes, vecs[i].tick, vecs[i].ready);
      checkOutput({vecs[i].name, " valid"}, 32'(aer_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        checkOutput({vecs[i].name, " addr"}, 32'(aer_addr), 32'(vecs[i].exp_addr));
      checkOutput({vecs[i].name, " acks"}, 32'(acks_out), 32'(vecs[i].exp_acks));
      checkOutput({vecs[i].name, " busy"}, 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput({vecs[i].name, " done"}, 32'(done), 32'(vecs[i].exp_done));
      checkOutput({vecs[i].name, " drop"}, 32'(drop), 32'(vecs[i].exp_drop));
      checkOutput({vecs[i].name, " event_cnt"}, 32'(event_cnt), 32'(vecs[i].exp_cnt));
    end

    // Repeated spike on neuron 3 while it waits behind neuron 0 under back-pressure.
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(1, 8'h09, 0, 0);
    applyStimulus(1, 8'h08, 0, 0);
    checkOutput("drop set", 32'(drop), 32'd1);
    checkOutput("drop first addr", 32'(aer_addr), 32'd0);
    n3 = 0;
    nev = 0;
    aer_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (aer_valid) nev++;
      if (aer_valid && aer_addr == 3'd3) n3++;
      applyStimulus(1, 8'h00, 0, 1);
    end
    checkOutput("drop events", 32'(nev), 32'd2);
    checkOutput("drop addr3 count", 32'(n3), 32'd1);
    checkOutput("drop sticky", 32'(drop), 32'd1);
    applyStimulus(1, 8'h00, 1, 1);
    got_done = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      applyStimulus(1, 8'h00, 0, 1);
      got_done = done;
    end
    checkOutput("drop done seen", 32'(got_done), 32'd1);
    checkOutput("drop event_cnt", 32'(event_cnt), 32'd2);
    applyStimulus(1, 8'h00, 0, 1);
    checkOutput("drop cleared", 32'(drop), 32'd0);
    checkOutput("drop done pulse", 32'(done), 32'd0);

    // Reset while an event is in flight and three neurons are still waiting.
    applyStimulus(1, 8'h0F, 0, 0);
    applyStimulus(1, 8'h00, 0, 0);
    checkOutput("mid valid", 32'(aer_valid), 32'd1);
    checkOutput("mid busy", 32'(busy), 32'd1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("rst valid", 32'(aer_valid), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h00, 0, 1);
      if (aer_valid || busy) quiet++;
    end
    checkOutput("rst no events", 32'(quiet), 32'd0);
    applyStimulus(1, 8'hFF, 0, 1);
    applyStimulus(1, 8'h00, 0, 1);
    checkOutput("rst ptr addr0", 32'(aer_addr), 32'd0);
    checkOutput("rst ptr acks0", 32'(acks_out), 32'h01);
    applyStimulus(1, 8'h00, 0, 1);
    checkOutput("rst ptr addr1", 32'(aer_addr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/aer_spike_arbiter.md
Name: aer_spike_arbiter

Overview:
- Sequential round-robin arbiter that serialises single-cycle spike pulses from N neuron outputs onto one address-event (AER) output port with valid/ready handshake.
- Latches each spike as pending until granted, so simultaneous spikes are not lost.
- Sits between the neuron array and the downstream synapse/layer router.
- Provides timestep-boundary flush (tick to done) and drop detection for the layer-level sequencer.

Parameters:
- N_NEURONS, 8, number of spike requesters.
- ADDR_W, 3, address width; must equal clog2(N_NEURONS).
- CNT_W, 8, width of per-timestep event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- spikes_in  input  N_NEURONS  per-neuron spike pulses; each set bit is one event.
- tick  input  1  timestep boundary request; one-cycle pulse.
- acks_out  output  N_NEURONS  one-hot pulse marking the neuron whose event was just loaded to the output.
- aer_valid  output  1  output event valid.
- aer_addr  output  ADDR_W  address of the spiking neuron.
- aer_ready  input  1  downstream accepts when aer_valid && aer_ready.
- busy  output  1  high when pending != 0, aer_valid is high, or state == FLUSH.
- done  output  1  one-cycle pulse when a flush completes.
- drop  output  1  sticky flag: a spike hit an already-pending neuron.
- event_cnt  output  CNT_W  events accepted downstream in the last completed timestep.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs and internal state cleared:
  - pending=0, rr_ptr=0, aer_valid=0, aer_addr=0, acks_out=0, done=0, drop=0, event_cnt=0, run_cnt=0, state=IDLE.
  - Reset mid-operation discards all pending and in-flight events.
- Pending register update each edge: pending <= (pending & ~grant) | spikes_in.
  - Spike on neuron i in the same cycle as grant[i]: pending[i] stays 1 and counts as a second event.
  - Spike on neuron i while pending[i]=1 and grant[i]=0: event is lost and drop is set.
  - drop is cleared only by reset or by the done pulse (done has priority over a new set in the same cycle).
- Load enable: load = (aer_valid==0 || aer_ready) && pending != 0.
- Grant: combinational one-hot from pending.
  - Search starts at index rr_ptr, increasing with wrap N_NEURONS-1 to 0; first set bit wins.
  - grant = 0 when load = 0.
- On load at an edge:
  - aer_addr <= index of grant, aer_valid <= 1, acks_out <= grant, rr_ptr <= (index+1) mod N_NEURONS.
  - acks_out is high for exactly the one cycle following the load edge; otherwise 0.
- On handshake (aer_valid && aer_ready) with no load: aer_valid <= 0.
  - Back-to-back loads give one event per cycle while aer_ready stays 1.
  - aer_addr is held stable while aer_valid && !aer_ready.
- Latency:
  - Spike at edge k sets pending after edge k.
  - Event is loaded at edge k+1 if the output stage is free, so aer_valid rises 2 edges after the spike is sampled.
- run_cnt increments on each handshake and saturates at 2^CNT_W-1.
- State machine (2-bit):
  - IDLE: pending==0 and output empty.
    - Goes to ACTIVE when pending != 0.
    - On tick, goes to FLUSH.
  - ACTIVE: arbitration running.
    - On tick, goes to FLUSH.
    - Returns to IDLE when pending==0 and aer_valid==0.
  - FLUSH: arbitration continues; spikes arriving in FLUSH are still accepted and drained.
    - Exits when pending==0, aer_valid==0 and no spike this cycle.
    - On exit: done<=1 for 1 cycle, event_cnt<=run_cnt (including a handshake on the exit cycle), run_cnt<=0, state<=IDLE.
  - tick while in FLUSH is ignored.
  - tick in IDLE with nothing pending: done pulses 2 edges after tick is sampled.
- rr_ptr is not changed by tick or done.

Decomposition:
- Shared package snn_aer_pkg holds:
  - state enum (IDLE, ACTIVE, FLUSH);
  - default N_NEURONS/ADDR_W/CNT_W constants;
  - function onehot_to_index.
- One natural sub-module: rr_priority_picker (combinational round-robin grant from pending and rr_ptr, outputs grant one-hot and index).
- The FSM, pending register, output stage and counter stay in the top module.

Test Plan:
- Reset then spikes_in=8'b1000_0001 for one cycle, aer_ready=1:
  - aer_addr 0 then 7 on consecutive cycles;
  - acks_out 8'h01 then 8'h80;
  - aer_valid high 2 cycles, then 0.
- spikes_in=8'hFF for one cycle, aer_ready=1:
  - addresses 0,1,...,7 in 8 consecutive cycles;
  - a second 8'hFF burst issued after the drain yields 0..7 again (rr_ptr has wrapped to 0).
- Back-pressure: aer_ready=0 for 5 cycles with pending 8'h24:
  - aer_addr=2 held stable with aer_valid=1 and no acks_out pulse;
  - after aer_ready=1: addr 2, then 5.
- Repeated spike on neuron 3 while pending and not granted:
  - drop=1 and only one event with address 3 is output;
  - drop clears on the next done pulse.
- spikes_in=8'h0F, tick one cycle later, aer_ready=1:
  - 4 events with addresses 0..3;
  - done pulses once after the last handshake and event_cnt=4;
  - tick in IDLE with no spikes gives done after 2 edges and event_cnt=0.
- rst_n=0 while 3 spikes are pending and aer_valid=1:
  - next cycle aer_valid=0, busy=0, no further events;
  - rr_ptr restarts at 0 (next 8'hFF burst starts at address 0).
